// File: rtl/alu_pkg.sv
// Shared constants and the issued-beat type for the ALU issue path.
package alu_pkg;

    localparam int BEAT_XLEN   = 32;
    localparam int BEAT_CTRL_W = 8;

    // ALU control codes; NONE makes the ALU return 0
    localparam logic [BEAT_CTRL_W-1:0] CTRL_NONE = 8'h00;
    localparam logic [BEAT_CTRL_W-1:0] CTRL_ADD  = 8'h01;
    localparam logic [BEAT_CTRL_W-1:0] CTRL_SUB  = 8'h02;
    localparam logic [BEAT_CTRL_W-1:0] CTRL_MUL  = 8'h03;
    localparam logic [BEAT_CTRL_W-1:0] CTRL_DIV  = 8'h04;
    localparam logic [BEAT_CTRL_W-1:0] CTRL_XOR  = 8'h05;
    localparam logic [BEAT_CTRL_W-1:0] CTRL_AND  = 8'h06;
    localparam logic [BEAT_CTRL_W-1:0] CTRL_OR   = 8'h07;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

    typedef struct packed {
        logic [BEAT_XLEN-1:0]   op1;
        logic [BEAT_XLEN-1:0]   op2;
        logic [BEAT_CTRL_W-1:0] ctrl;
        logic [4:0]             rd;
        logic                   illegal;
    } beat_t;

endpackage

// File: rtl/alu_decode.sv
// Combinational decode: raw instruction plus register data -> issued beat.
// Optional writeback bypass on rs1/rs2 when EX_FWD_EN is defined.
module alu_decode
    import alu_pkg::*;
(
    input  logic [BEAT_XLEN-1:0] i_instr,
    input  logic [BEAT_XLEN-1:0] i_rs1_data,
    input  logic [BEAT_XLEN-1:0] i_rs2_data,
    input  logic                 i_wb_valid,
    input  logic [4:0]           i_wb_rd,
    input  logic [BEAT_XLEN-1:0] i_wb_data,
    output beat_t                o_beat
);

    logic [6:0]           w_opcode;
    logic [2:0]           w_f3;
    logic [6:0]           w_f7;
    logic [BEAT_XLEN-1:0] w_rs1;
    logic [BEAT_XLEN-1:0] w_rs2;
    logic [BEAT_XLEN-1:0] w_imm;

    assign w_opcode = i_instr[6:0];
    assign w_f3     = i_instr[14:12];
    assign w_f7     = i_instr[31:25];
    assign w_imm    = {{(BEAT_XLEN-12){i_instr[31]}}, i_instr[31:20]};

`ifdef EX_FWD_EN
    // x0 is never bypassed: its architectural value is always zero
    assign w_rs1 = (i_wb_valid && (i_wb_rd != 5'd0) && (i_wb_rd == i_instr[19:15]))
                   ? i_wb_data : i_rs1_data;
    assign w_rs2 = (i_wb_valid && (i_wb_rd != 5'd0) && (i_wb_rd == i_instr[24:20]))
                   ? i_wb_data : i_rs2_data;
`else
    logic w_unused_wb;
    assign w_unused_wb = &{1'b0, i_wb_valid, i_wb_rd, i_wb_data};
    assign w_rs1 = i_rs1_data;
    assign w_rs2 = i_rs2_data;
`endif

    // Opcode/funct decode; anything unrecognised issues as an illegal NONE op
    always_comb begin
        o_beat         = '0;
        o_beat.rd      = i_instr[11:7];
        o_beat.ctrl    = CTRL_NONE;
        o_beat.illegal = 1'b1;
        if (w_opcode == OP_R) begin
            o_beat.illegal = 1'b0;
            case ({w_f7, w_f3})
                {7'b0000000, 3'b000}: o_beat.ctrl = CTRL_ADD;
                {7'b0100000, 3'b000}: o_beat.ctrl = CTRL_SUB;
                {7'b0000001, 3'b000}: o_beat.ctrl = CTRL_MUL;
                {7'b0000000, 3'b100}: o_beat.ctrl = CTRL_XOR;
                {7'b0000001, 3'b100}: o_beat.ctrl = CTRL_DIV;
                {7'b0000000, 3'b111}: o_beat.ctrl = CTRL_AND;
                {7'b0000000, 3'b110}: o_beat.ctrl = CTRL_OR;
                default:              o_beat.illegal = 1'b1;
            endcase
            o_beat.op1 = w_rs1;
            o_beat.op2 = w_rs2;
        end else if (w_opcode == OP_I) begin
            o_beat.illegal = 1'b0;
            case (w_f3)
                3'b000:  o_beat.ctrl = CTRL_ADD;
                3'b100:  o_beat.ctrl = CTRL_XOR;
                3'b111:  o_beat.ctrl = CTRL_AND;
                3'b110:  o_beat.ctrl = CTRL_OR;
                default: o_beat.illegal = 1'b1;
            endcase
            o_beat.op1 = w_rs1;
            o_beat.op2 = w_imm;
        end
        // Illegal beats still flow so the trap logic sees them, but carry no operands
        if (o_beat.illegal) begin
            o_beat.ctrl = CTRL_NONE;
            o_beat.op1  = '0;
            o_beat.op2  = '0;
        end
    end

endmodule

// File: rtl/ex_issue_stage.sv
// Issue stage in front of the ALU: decode, one output register and a
// 1-entry skid buffer behind valid/ready. Optional macro: EX_FWD_EN
// (writeback bypass into the operand select).
module ex_issue_stage
    import alu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_instr,
    input  logic [XLEN-1:0]   in_rs1_data,
    input  logic [XLEN-1:0]   in_rs2_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_op1,
    output logic [XLEN-1:0]   out_op2,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [4:0]        out_rd,
    output logic              out_illegal,
    input  logic              wb_valid,
    input  logic [4:0]        wb_rd,
    input  logic [XLEN-1:0]   wb_data
);

    beat_t r_main;
    beat_t r_skid;
    logic  r_valid;
    logic  r_skid_vld;
    beat_t w_beat;
    logic  w_accept;

    alu_decode u_decode (
        .i_instr    (in_instr),
        .i_rs1_data (in_rs1_data),
        .i_rs2_data (in_rs2_data),
        .i_wb_valid (wb_valid),
        .i_wb_rd    (wb_rd),
        .i_wb_data  (wb_data),
        .o_beat     (w_beat)
    );

    // in_ready comes straight from a flop: the stage is open iff the skid is empty
    assign in_ready = ~r_skid_vld;
    assign w_accept = in_valid & ~r_skid_vld;

    // Main register refills from skid first, else from the input; a stalled
    // main register parks an accepted beat in the skid. Flush wins over accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main     <= '0;
            r_skid     <= '0;
            r_valid    <= 1'b0;
            r_skid_vld <= 1'b0;
        end else if (flush) begin
            r_valid    <= 1'b0;
            r_skid_vld <= 1'b0;
        end else if (!r_valid || out_ready) begin
            if (r_skid_vld) begin
                r_main     <= r_skid;
                r_valid    <= 1'b1;
                r_skid_vld <= 1'b0;
            end else if (w_accept) begin
                r_main  <= w_beat;
                r_valid <= 1'b1;
            end else begin
                r_valid <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid     <= w_beat;
            r_skid_vld <= 1'b1;
        end
    end

    assign out_valid   = r_valid;
    assign out_op1     = r_main.op1;
    assign out_op2     = r_main.op2;
    assign out_ctrl    = r_main.ctrl;
    assign out_rd      = r_main.rd;
    assign out_illegal = r_main.illegal;

endmodule

// File: tb/tb_ex_issue_stage.sv
// Directed bench for ex_issue_stage: decode vectors, skid stall/drain,
// flush, async reset and (if EX_FWD_EN) the writeback bypass.
module tb_ex_issue_stage;

`ifdef EX_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_rs1_data = '0;
    logic [31:0] in_rs2_data = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_op1;
    logic [31:0] out_op2;
    logic [7:0]  out_ctrl;
    logic [4:0]  out_rd;
    logic        out_illegal;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;

    int n_chk  = 0;
    int n_fail = 0;

    ex_issue_stage dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_op1(out_op1),
        .out_op2(out_op2), .out_ctrl(out_ctrl), .out_rd(out_rd),
        .out_illegal(out_illegal), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // advance one rising edge, then settle outputs away from the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] itype(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    task automatic drive(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b);
        in_instr    = instr;
        in_rs1_data = a;
        in_rs2_data = b;
        in_valid    = 1'b1;
    endtask

    // issue one beat with out_ready high and check the registered result
    task automatic issue_chk(input string tag, input logic [31:0] instr,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] e_op1, input logic [31:0] e_op2,
                             input logic [7:0] e_ctrl, input logic e_ill);
        drive(instr, a, b);
        step();
        in_valid = 1'b0;
        chk({tag, ".vld"},  {31'd0, out_valid},   32'd1);
        chk({tag, ".op1"},  out_op1,              e_op1);
        chk({tag, ".op2"},  out_op2,              e_op2);
        chk({tag, ".ctrl"}, {24'd0, out_ctrl},    {24'd0, e_ctrl});
        chk({tag, ".rd"},   {27'd0, out_rd},      {27'd0, instr[11:7]});
        chk({tag, ".ill"},  {31'd0, out_illegal}, {31'd0, e_ill});
    endtask

    initial begin
        // reset state
        #2;
        chk("rst.vld",  {31'd0, out_valid},   32'd0);
        chk("rst.rdy",  {31'd0, in_ready},    32'd1);
        chk("rst.op1",  out_op1,              32'd0);
        chk("rst.op2",  out_op2,              32'd0);
        chk("rst.ctrl", {24'd0, out_ctrl},    32'd0);
        chk("rst.rd",   {27'd0, out_rd},      32'd0);
        chk("rst.ill",  {31'd0, out_illegal}, 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // decode vectors (one beat per cycle, out_ready high)
        issue_chk("add",  rtype(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 32'd5, 32'd7, 32'd5, 32'd7, 8'h01, 1'b0);
        chk("add.rd3", {27'd0, out_rd}, 32'd3);
        issue_chk("addi", itype(12'hFFF, 5'd1, 3'b000, 5'd4), 32'd10, 32'd77, 32'd10, 32'hFFFF_FFFF, 8'h01, 1'b0);
        issue_chk("mul",  rtype(7'h01, 5'd2, 5'd1, 3'b000, 5'd5), 32'd6, 32'd9, 32'd6, 32'd9, 8'h03, 1'b0);
        issue_chk("div",  rtype(7'h01, 5'd2, 5'd1, 3'b100, 5'd6), 32'd8, 32'd2, 32'd8, 32'd2, 8'h04, 1'b0);
        issue_chk("sub",  rtype(7'h20, 5'd2, 5'd1, 3'b000, 5'd7), 32'd9, 32'd4, 32'd9, 32'd4, 8'h02, 1'b0);
        issue_chk("xor",  rtype(7'h00, 5'd2, 5'd1, 3'b100, 5'd8), 32'hA, 32'hB, 32'hA, 32'hB, 8'h05, 1'b0);
        issue_chk("and",  rtype(7'h00, 5'd2, 5'd1, 3'b111, 5'd9), 32'hC, 32'hD, 32'hC, 32'hD, 8'h06, 1'b0);
        issue_chk("or",   rtype(7'h00, 5'd2, 5'd1, 3'b110, 5'd10), 32'hE, 32'hF, 32'hE, 32'hF, 8'h07, 1'b0);
        issue_chk("xori", itype(12'h7F0, 5'd1, 3'b100, 5'd11), 32'h1, 32'h2, 32'h1, 32'h0000_07F0, 8'h05, 1'b0);
        issue_chk("andi", itype(12'h800, 5'd1, 3'b111, 5'd12), 32'h3, 32'h2, 32'h3, 32'hFFFF_F800, 8'h06, 1'b0);
        issue_chk("load", {12'h004, 5'd1, 3'b010, 5'd13, 7'b0000011}, 32'h55, 32'h66, 32'd0, 32'd0, 8'h00, 1'b1);
        issue_chk("r_bad", rtype(7'h00, 5'd2, 5'd1, 3'b001, 5'd14), 32'h55, 32'h66, 32'd0, 32'd0, 8'h00, 1'b1);
        step();
        chk("idle.vld", {31'd0, out_valid}, 32'd0);

        // stall: A into main, B into skid, C refused
        out_ready = 1'b0;
        drive(rtype(7'h00, 5'd2, 5'd1, 3'b000, 5'd1), 32'hA0, 32'h1);
        step();
        chk("stall.rdyA", {31'd0, in_ready}, 32'd1);
        drive(rtype(7'h00, 5'd2, 5'd1, 3'b000, 5'd2), 32'hB0, 32'h2);
        step();
        chk("stall.rdyB", {31'd0, in_ready}, 32'd0);
        chk("stall.holdA", out_op1, 32'hA0);
        drive(rtype(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 32'hC0, 32'h3);
        step();
        in_valid = 1'b0;
        chk("stall.holdA2", out_op1, 32'hA0);
        chk("stall.holdrd", {27'd0, out_rd}, 32'd1);
        out_ready = 1'b1;
        step();
        chk("drain.vldB", {31'd0, out_valid}, 32'd1);
        chk("drain.B", out_op1, 32'hB0);
        chk("drain.rdy", {31'd0, in_ready}, 32'd1);
        step();
        chk("drain.empty", {31'd0, out_valid}, 32'd0);

        // back-to-back with drain: throughput 1/cycle
        for (int i = 0; i < 3; i++) begin
            drive(rtype(7'h00, 5'd2, 5'd1, 3'b000, 5'd4), 32'h100 + i, 32'd0);
            step();
            chk("b2b.vld", {31'd0, out_valid}, 32'd1);
            chk("b2b.op1", out_op1, 32'h100 + i);
        end
        in_valid = 1'b0;
        step();

        // flush with main, skid and a new input all live
        out_ready = 1'b0;
        drive(rtype(7'h00, 5'd2, 5'd1, 3'b000, 5'd1), 32'hD1, 32'd0);
        step();
        drive(rtype(7'h00, 5'd2, 5'd1, 3'b000, 5'd2), 32'hD2, 32'd0);
        step();
        chk("fl.pre_rdy", {31'd0, in_ready}, 32'd0);
        drive(rtype(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 32'hD3, 32'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl.vld", {31'd0, out_valid}, 32'd0);
        chk("fl.rdy", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("fl.gone", {31'd0, out_valid}, 32'd0);
        end

        // asynchronous reset mid-operation
        out_ready = 1'b0;
        drive(rtype(7'h00, 5'd2, 5'd1, 3'b000, 5'd1), 32'hE1, 32'd0);
        step();
        drive(rtype(7'h00, 5'd2, 5'd1, 3'b000, 5'd2), 32'hE2, 32'd0);
        step();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.vld", {31'd0, out_valid}, 32'd0);
        chk("arst.rdy", {31'd0, in_ready}, 32'd1);
        chk("arst.op1", out_op1, 32'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        chk("arst.after", {31'd0, out_valid}, 32'd0);

        // writeback bypass (only takes effect with EX_FWD_EN)
        wb_valid = 1'b1;
        wb_rd    = 5'd1;
        wb_data  = 32'd99;
        issue_chk("fwd.rs1", rtype(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 32'd5, 32'd7,
                  FWD ? 32'd99 : 32'd5, 32'd7, 8'h01, 1'b0);
        issue_chk("fwd.rs2", rtype(7'h00, 5'd1, 5'd2, 3'b000, 5'd3), 32'd5, 32'd7,
                  32'd5, FWD ? 32'd99 : 32'd7, 8'h01, 1'b0);
        issue_chk("fwd.imm", itype(12'h001, 5'd1, 3'b000, 5'd3), 32'd5, 32'd7,
                  FWD ? 32'd99 : 32'd5, 32'd1, 8'h01, 1'b0);
        wb_rd = 5'd0;
        issue_chk("fwd.x0", rtype(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 32'd5, 32'd7,
                  32'd5, 32'd7, 8'h01, 1'b0);
        wb_valid = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
